seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture_if.sv | 26 ++
 rtl/seg7_capture.sv | 123 ++++++++++++
 tb/tb_seg7_capture.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// Purpose: bundles the seven-segment capture strobe bus and the captured-word outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the strobes are fire-and-forget and rd_en gates their sampling.
interface seg7_capture_if;
  logic        rd_en;
  logic [6:0]  seg_in;
  logic [2:0]  digit_sel;
  logic        digit_strobe;
  logic [31:0] value;
  logic        valid;
  logic        err;
  logic        timeout;
  logic [7:0]  digit_mask;

  // The source of the strobes (display scanner or testbench)
  modport master (
    output rd_en, seg_in, digit_sel, digit_strobe,
    input  value, valid, err, timeout, digit_mask
  );

  // The capture block
  modport slave (
    input  rd_en, seg_in, digit_sel, digit_strobe,
    output value, valid, err, timeout, digit_mask
  );
endinterface

// File: rtl/seg7_capture.sv
// Purpose: decodes strobed active-low 7-segment digits into nibbles and assembles a 32-bit word.
// Latency: valid/err pulse 1 cycle after the sampled strobe; timeout pulses at the edge ending
//          the TIMEOUT-th consecutive strobe-less cycle in COLLECT.
// Backpressure: none; strobes are ignored while rd_en=0, and no strobe is ever stalled.
module seg7_capture #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  seg7_capture_if.slave bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  // The counter holds the number of strobe-less COLLECT cycles already elapsed,
  // so the cycle that would bring it to TIMEOUT is the expiry cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] shadow;
  logic [31:0] value_q;
  logic [7:0]  mask_q;
  logic [15:0] idle_cnt;
  logic        valid_q;
  logic        err_q;
  logic        timeout_q;

  logic        sample;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic [7:0]  sel_bit;
  logic [31:0] word_next;

  assign sample  = bus.rd_en & bus.digit_strobe;
  assign sel_bit = 8'(1) << bus.digit_sel;

  // Segment pattern to nibble lookup; anything outside the table is undecodable
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (bus.seg_in)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Shadow word with the nibble currently being decoded merged in
  always_comb begin
    word_next = shadow;
    word_next[{bus.digit_sel, 2'b00} +: 4] = dec_nib;
  end

  // Capture FSM: strobe handling has priority over timeout expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      value_q   <= '0;
      mask_q    <= '0;
      idle_cnt  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      if (sample) begin
        idle_cnt <= '0;
        if (dec_ok) begin
          shadow <= word_next;
          if ((mask_q | sel_bit) == 8'hFF) begin
            value_q <= word_next;
            valid_q <= 1'b1;
            mask_q  <= '0;
            state   <= IDLE;
          end else begin
            mask_q <= mask_q | sel_bit;
            state  <= COLLECT;
          end
        end else begin
          // The stale nibble stays in shadow; only its mask bit is dropped
          err_q  <= 1'b1;
          mask_q <= mask_q & ~sel_bit;
          state  <= ((mask_q & ~sel_bit) == 8'h00) ? IDLE : COLLECT;
        end
      end else if (state == COLLECT) begin
        if (idle_cnt >= CNT_LAST) begin
          timeout_q <= 1'b1;
          mask_q    <= '0;
          idle_cnt  <= '0;
          state     <= IDLE;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign bus.value      = value_q;
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;
  assign bus.digit_mask = mask_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Purpose: directed self-checking bench for seg7_capture (TIMEOUT=4).
// Latency: inputs change 1ns after a rising edge, outputs are read at the same point.
// Backpressure: not applicable.
module tb_seg7_capture;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg7_capture_if bus ();

  seg7_capture #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b0000001;
      4'h1: p = 7'b1001111;
      4'h2: p = 7'b0010010;
      4'h3: p = 7'b0000110;
      4'h4: p = 7'b1001100;
      4'h5: p = 7'b0100100;
      4'h6: p = 7'b0100000;
      4'h7: p = 7'b0001111;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0000100;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b1100000;
      4'hC: p = 7'b0110001;
      4'hD: p = 7'b1000010;
      4'hE: p = 7'b0110000;
      default: p = 7'b0111000;
    endcase
    return p;
  endfunction

  // One strobe for one cycle; returns 1ns after the sampling edge
  task automatic send(input logic [2:0] sel, input logic [6:0] seg);
    bus.digit_strobe = 1'b1;
    bus.digit_sel    = sel;
    bus.seg_in       = seg;
    @(posedge clk); #1;
    bus.digit_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checks++;
    if (bus.value !== 32'h0 || bus.valid !== 1'b0 || bus.err !== 1'b0 ||
        bus.timeout !== 1'b0 || bus.digit_mask !== 8'h00) begin
      errors++;
      $display("FAIL reset: value=%h valid=%b err=%b timeout=%b mask=%h, required 0/0/0/0/00",
               bus.value, bus.valid, bus.err, bus.timeout, bus.digit_mask);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 7; i++) send(3'(i), pat(4'(8 - i)));
    checks++;
    if (bus.digit_mask !== 8'h7F || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_partial: mask=%h valid=%b, required 7f/0", bus.digit_mask, bus.valid);
    end
    send(3'd7, pat(4'h1));
    checks++;
    if (bus.value !== 32'h12345678 || bus.valid !== 1'b1 || bus.digit_mask !== 8'h00) begin
      errors++;
      $display("FAIL basic_complete: value=%h valid=%b mask=%h, required 12345678/1/00",
               bus.value, bus.valid, bus.digit_mask);
    end
    idle(1);
    checks++;
    if (bus.valid !== 1'b0 || bus.value !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_hold: valid=%b value=%h, required 0/12345678", bus.valid, bus.value);
    end
  endtask

  task automatic test_overwrite;
    for (int i = 0; i < 7; i++) send(3'(i), pat(4'(i)));
    send(3'd3, 7'b0110001);
    checks++;
    if (bus.digit_mask !== 8'h7F || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_mask: mask=%h valid=%b, required 7f/0", bus.digit_mask, bus.valid);
    end
    send(3'd7, 7'b0000000);
    checks++;
    if (bus.value !== 32'h8654C210 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL overwrite_value: value=%h valid=%b, required 8654c210/1", bus.value, bus.valid);
    end
    idle(1);
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_single_pulse: valid=%b, required 0", bus.valid);
    end
  endtask

  task automatic test_invalid;
    send(3'd0, pat(4'h5));
    send(3'd2, pat(4'h3));
    send(3'd2, 7'b1111111);
    checks++;
    if (bus.err !== 1'b1 || bus.digit_mask !== 8'h01 || bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL invalid_blank: err=%b mask=%h valid=%b timeout=%b, required 1/01/0/0",
               bus.err, bus.digit_mask, bus.valid, bus.timeout);
    end
    send(3'd0, 7'b1111110);
    checks++;
    if (bus.err !== 1'b1 || bus.digit_mask !== 8'h00) begin
      errors++;
      $display("FAIL invalid_to_idle: err=%b mask=%h, required 1/00", bus.err, bus.digit_mask);
    end
    idle(1);
    checks++;
    if (bus.err !== 1'b0 || bus.value !== 32'h8654C210) begin
      errors++;
      $display("FAIL invalid_after: err=%b value=%h, required 0/8654c210", bus.err, bus.value);
    end
  endtask

  task automatic test_timeout;
    int hits;
    send(3'd0, pat(4'h9));
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (bus.timeout === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL timeout_early: pulses=%0d, required 0", hits);
    end
    idle(1);
    checks++;
    if (bus.timeout !== 1'b1 || bus.digit_mask !== 8'h00 || bus.value !== 32'h8654C210 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: timeout=%b mask=%h value=%h valid=%b, required 1/00/8654c210/0",
               bus.timeout, bus.digit_mask, bus.value, bus.valid);
    end
    idle(1);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: timeout=%b, required 0", bus.timeout);
    end
    // Strobe lands on the expiry cycle: no pulse, capture continues
    send(3'd0, pat(4'h9));
    idle(3);
    send(3'd1, pat(4'h2));
    checks++;
    if (bus.timeout !== 1'b0 || bus.digit_mask !== 8'h03) begin
      errors++;
      $display("FAIL timeout_strobe_priority: timeout=%b mask=%h, required 0/03", bus.timeout, bus.digit_mask);
    end
    // rd_en low keeps the partial state but the counter still runs
    bus.rd_en = 1'b0;
    for (int i = 0; i < 3; i++) send(3'(i + 2), pat(4'h4));
    checks++;
    if (bus.digit_mask !== 8'h03 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL rd_en_hold: mask=%h timeout=%b, required 03/0", bus.digit_mask, bus.timeout);
    end
    send(3'd5, pat(4'h4));
    bus.rd_en = 1'b1;
    checks++;
    if (bus.timeout !== 1'b1 || bus.digit_mask !== 8'h00) begin
      errors++;
      $display("FAIL rd_en_timeout: timeout=%b mask=%h, required 1/00", bus.timeout, bus.digit_mask);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    for (int i = 0; i < 5; i++) send(3'(i), pat(4'(i + 1)));
    rst = 1'b1;
    send(3'd5, pat(4'h6));
    rst = 1'b0;
    checks++;
    if (bus.digit_mask !== 8'h00 || bus.value !== 32'h0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: mask=%h value=%h valid=%b, required 00/00000000/0",
               bus.digit_mask, bus.value, bus.valid);
    end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      send(3'(i), pat(4'hF));
      if (bus.valid === 1'b1 || bus.value !== 32'h0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_hold: early changes=%0d, required 0", pulses);
    end
    send(3'd7, pat(4'hF));
    checks++;
    if (bus.value !== 32'hFFFFFFFF || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_complete: value=%h valid=%b, required ffffffff/1", bus.value, bus.valid);
    end
  endtask

  task automatic test_rd_en_off;
    int bad;
    bad = 0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), pat(4'(i)));
      if (bus.valid !== 1'b0 || bus.err !== 1'b0 || bus.digit_mask !== 8'h00) bad++;
    end
    bus.rd_en = 1'b1;
    checks++;
    if (bad != 0 || bus.value !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL rd_en_off: bad cycles=%0d value=%h, required 0/ffffffff", bad, bus.value);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) send(3'(7 - i), pat(4'hA));
    checks++;
    if (bus.value !== 32'hAAAAAAAA || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: value=%h valid=%b, required aaaaaaaa/1", bus.value, bus.valid);
    end
    for (int i = 0; i < 8; i++) send(3'(i), pat(4'(4'hB + i[0])));
    checks++;
    if (bus.value !== 32'hCBCBCBCB || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: value=%h valid=%b, required cbcbcbcb/1", bus.value, bus.valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rd_en = 1'b1;
    bus.digit_strobe = 1'b0;
    bus.digit_sel = 3'd0;
    bus.seg_in = 7'b1111111;
    test_reset();
    test_basic();
    test_overwrite();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_rd_en_off();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
